// File: rtl/tick_wave_gen_if.sv
// Configuration handshake bundle for tick_wave_gen: the requested period and high time,
// offered with cfg_valid and accepted on cfg_ready.
interface tick_wave_gen_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;

  modport master (output cfg_valid, output cfg_period, output cfg_high, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_period, input cfg_high, output cfg_ready);
endinterface

// File: rtl/tick_wave_gen.sv
// Programmable tick strobe / square-wave generator with a one-deep pending config slot and lock status.
// Optional macro TICK_WAVE_GEN_SYNC_EN inserts a 2-flop synchronizer on enable.
module tick_wave_gen #(
  parameter int CNT_W        = 8,
  parameter int DEF_PERIOD   = 10,
  parameter int DEF_HIGH     = 5,
  parameter int LOCK_PERIODS = 4
) (
  input  logic           clk100,
  input  logic           rst,
  input  logic           enable,
  tick_wave_gen_if.slave cfg,
  output logic           tick,
  output logic           wave_out,
  output logic           running,
  output logic           locked
);

  localparam int LOCK_W = $clog2(LOCK_PERIODS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Smallest legal period is 2 so the wave always has both a high and a low cycle.
  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
    logic [CNT_W-1:0] r;
    if (p < CNT_W'(2)) r = CNT_W'(2);
    else               r = p;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_high(input logic [CNT_W-1:0] h,
                                                  input logic [CNT_W-1:0] p);
    logic [CNT_W-1:0] r;
    if (h == {CNT_W{1'b0}}) r = CNT_W'(1);
    else                    r = h;
    if (r >= p) r = p - CNT_W'(1);
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic              pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0]  pend_per_q, pend_per_d;
  logic [CNT_W-1:0]  pend_high_q, pend_high_d;
  logic [LOCK_W-1:0] lock_q, lock_d;

  logic             en_s;
  logic             cfg_accept_s;
  logic             last_s;
  logic [CNT_W-1:0] new_per_s;
  logic [CNT_W-1:0] new_high_s;

`ifdef TICK_WAVE_GEN_SYNC_EN
  (* ASYNC_REG = "TRUE" *) logic en_meta_q;
  (* ASYNC_REG = "TRUE" *) logic en_sync_q;

  // Two-stage synchronizer for an enable coming from another clock domain.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      en_meta_q <= 1'b0;
      en_sync_q <= 1'b0;
    end else begin
      en_meta_q <= enable;
      en_sync_q <= en_meta_q;
    end
  end
  assign en_s = en_sync_q;
`else
  assign en_s = enable;
`endif

  assign cfg.cfg_ready = ~pend_valid_q;
  assign cfg_accept_s  = cfg.cfg_valid & ~pend_valid_q;
  assign new_per_s     = clamp_period(cfg.cfg_period);
  assign new_high_s    = clamp_high(cfg.cfg_high, new_per_s);
  assign last_s        = (cnt_q == (per_q - CNT_W'(1)));

  assign running  = (state_q != ST_IDLE);
  assign tick     = running & last_s;
  assign wave_out = running & (cnt_q < high_q);
  assign locked   = (lock_q == LOCK_W'(LOCK_PERIODS));

  // Next-state, phase counter, config slots and lock counter.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    per_d        = per_q;
    high_d       = high_q;
    pend_valid_d = pend_valid_q;
    pend_per_d   = pend_per_q;
    pend_high_d  = pend_high_q;
    lock_d       = lock_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = {CNT_W{1'b0}};
        lock_d = {LOCK_W{1'b0}};
        if (cfg_accept_s) begin
          per_d  = new_per_s;
          high_d = new_high_s;
        end else begin
          per_d  = per_q;
        end
        if (en_s) state_d = ST_RUN;
        else      state_d = ST_IDLE;
      end
      ST_RUN, ST_DRAIN: begin
        if (last_s) cnt_d = {CNT_W{1'b0}};
        else        cnt_d = cnt_q + CNT_W'(1);

        if (last_s && (state_q == ST_RUN) && (lock_q != LOCK_W'(LOCK_PERIODS))) begin
          lock_d = lock_q + LOCK_W'(1);
        end else begin
          lock_d = lock_q;
        end

        // An enable seen in DRAIN resumes RUN without disturbing the phase.
        if (en_s) begin
          state_d = ST_RUN;
        end else if (last_s) begin
          state_d = ST_IDLE;
          lock_d  = {LOCK_W{1'b0}};
        end else begin
          state_d = ST_DRAIN;
        end

        if (last_s && pend_valid_q) begin
          per_d        = pend_per_q;
          high_d       = pend_high_q;
          pend_valid_d = 1'b0;
          lock_d       = {LOCK_W{1'b0}};
        end else begin
          pend_valid_d = pend_valid_q;
        end

        // Accept only happens with the slot empty, so it never collides with a load.
        if (cfg_accept_s) begin
          pend_valid_d = 1'b1;
          pend_per_d   = new_per_s;
          pend_high_d  = new_high_s;
        end else begin
          pend_per_d   = pend_per_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        lock_d  = {LOCK_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      per_q        <= CNT_W'(DEF_PERIOD);
      high_q       <= CNT_W'(DEF_HIGH);
      pend_valid_q <= 1'b0;
      pend_per_q   <= {CNT_W{1'b0}};
      pend_high_q  <= {CNT_W{1'b0}};
      lock_q       <= {LOCK_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      per_q        <= per_d;
      high_q       <= high_d;
      pend_valid_q <= pend_valid_d;
      pend_per_q   <= pend_per_d;
      pend_high_q  <= pend_high_d;
      lock_q       <= lock_d;
    end
  end

endmodule
